hack_ctrl: RTL



---
 rtl/hack_pkg.sv | 35 +++
 rtl/hack_jump_eval.sv | 12 +
 rtl/hack_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack control unit: FSM states, IR field positions, opcodes.
// Pure declarations; no timing or flow-control behaviour.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MREAD,
    EXEC,
    MWRITE
  } state_t;

  localparam int CI_BIT  = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  localparam logic [15:0] OP_D_EQ_A     = 16'hEC10;
  localparam logic [15:0] OP_JMP        = 16'hEA87;
  localparam logic [15:0] OP_M_EQ_D_P_M = 16'hF088;
  localparam logic [15:0] OP_D_JEQ      = 16'hE302;
  localparam logic [15:0] OP_AM_EQ_A    = 16'hEC28;
  localparam logic [15:0] OP_A_EQ_M     = 16'hFC20;

  // IR comp field runs zx..no from MSB down; the ALU control word wants zx in bit 0.
  function automatic logic [5:0] comp_to_ctrl(input logic [5:0] comp);
    return {comp[0], comp[1], comp[2], comp[3], comp[4], comp[5]};
  endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Combinational jump decision from the IR jump bits and the ALU zr/ng flags.
// Zero latency, no handshake.
module hack_jump_eval (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  assign taken = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack control unit: fetch/decode, A/D/PC registers, M read/write, ALU sequencing.
// A-instr 2 cycles, C-instr 3 (+1 per M access); each memory state stalls with requests held until ack.
module hack_ctrl
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [15:0]       dmem_rdata,
  output logic [15:0]       alu_x,
  output logic [15:0]       alu_y,
  output logic [5:0]        alu_c,
  input  logic [15:0]       alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic              instr_done,
  output logic [ADDR_W-1:0] pc
);

  state_t            state, nstate;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       a_q, d_q, ir_q, m_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;
  logic [15:0]       x_q, y_q;
  logic [15:0]       y_sel;
  logic              taken;

  assign y_sel = ir_q[A_BIT] ? m_q : a_q;

  hack_jump_eval u_jump (
    .jump  (ir_q[JUMP_HI:JUMP_LO]),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .taken (taken)
  );

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_wdata = wdata_q;
  assign alu_x      = (state == EXEC) ? d_q   : x_q;
  assign alu_y      = (state == EXEC) ? y_sel : y_q;

  always_comb begin
    nstate     = state;
    imem_req   = 1'b0;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    dmem_addr  = a_q[ADDR_W-1:0];
    instr_done = 1'b0;
    alu_c      = '0;
    case (state)
      FETCH: begin
        // Reset forces FETCH asynchronously; keep the fetch request low while reset is held.
        imem_req = ~reset;
        if (imem_ack) nstate = DECODE;
      end
      DECODE: begin
        if (!ir_q[CI_BIT]) begin
          instr_done = 1'b1;
          nstate     = FETCH;
        end else if (ir_q[A_BIT]) begin
          nstate = MREAD;
        end else begin
          nstate = EXEC;
        end
      end
      MREAD: begin
        dmem_rd = 1'b1;
        if (dmem_ack) nstate = EXEC;
      end
      EXEC: begin
        alu_c = comp_to_ctrl(ir_q[COMP_HI:COMP_LO]);
        if (ir_q[DEST_M]) begin
          nstate = MWRITE;
        end else begin
          instr_done = 1'b1;
          nstate     = FETCH;
        end
      end
      MWRITE: begin
        dmem_wr   = 1'b1;
        dmem_addr = waddr_q;
        if (dmem_ack) begin
          instr_done = 1'b1;
          nstate     = FETCH;
        end
      end
      default: nstate = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc_q    <= PC_RESET;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state <= nstate;
      case (state)
        FETCH:  if (imem_ack) ir_q <= imem_data;
        DECODE: begin
          if (!ir_q[CI_BIT]) begin
            a_q  <= {1'b0, ir_q[14:0]};
            pc_q <= pc_q + 1'b1;
          end
        end
        MREAD:  if (dmem_ack) m_q <= dmem_rdata;
        EXEC: begin
          x_q <= d_q;
          y_q <= y_sel;
          if (ir_q[DEST_A]) a_q <= alu_out;
          if (ir_q[DEST_D]) d_q <= alu_out;
          // Write address and jump target both use A from before this instruction's update.
          if (ir_q[DEST_M]) begin
            waddr_q <= a_q[ADDR_W-1:0];
            wdata_q <= alu_out;
          end
          pc_q <= taken ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
